// File: rtl/sc_ir_fetch_controller_pkg.sv
// Shared encodings for the IR fetch microsequencer: FSM state codes and
// instruction-class (IR[31:30]) codes.
package sc_ir_fetch_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_DECODE = 3'd4,
    ST_EXEC   = 3'd5,
    ST_HALTED = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  localparam logic [1:0] OP_BRANCH = 2'b00;
  localparam logic [1:0] OP_CALL   = 2'b01;
  localparam logic [1:0] OP_ARITH  = 2'b10;
  localparam logic [1:0] OP_MEM    = 2'b11;

  function automatic logic fsm_busy(input state_t s);
    return !(s inside {ST_IDLE, ST_HALTED, ST_ERROR});
  endfunction

endpackage

// File: rtl/sc_ir_fetch_controller_if.sv
// Handshake and control bundle between the fetch microsequencer and the
// memory / IR / execute side of the datapath.
interface sc_ir_fetch_controller_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   SC_IrFetchCtrl_Start_InHigh;
  logic                   SC_IrFetchCtrl_Halt_InHigh;
  logic                   SC_IrFetchCtrl_MemReady_InHigh;
  logic                   SC_IrFetchCtrl_ExecDone_InHigh;
  logic [1:0]             SC_IrFetchCtrl_IR_OP;
  logic                   SC_IrFetchCtrl_IR_BIT13;
  logic                   SC_IrFetchCtrl_PC_EnableBusA;
  logic                   SC_IrFetchCtrl_MemRead_Out;
  logic                   SC_IrFetchCtrl_IR_Write_Out;
  logic                   SC_IrFetchCtrl_IR_EnableBusB;
  logic                   SC_IrFetchCtrl_ExecStart_Out;
  logic [1:0]             SC_IrFetchCtrl_Class_Out;
  logic                   SC_IrFetchCtrl_PcInc_Out;
  logic                   SC_IrFetchCtrl_Busy_Out;
  logic                   SC_IrFetchCtrl_Error_Out;
  logic [COUNT_WIDTH-1:0] SC_IrFetchCtrl_InstrCount_Out;
  logic [2:0]             SC_IrFetchCtrl_State_Out;

  modport master (
    input  SC_IrFetchCtrl_Start_InHigh, SC_IrFetchCtrl_Halt_InHigh,
           SC_IrFetchCtrl_MemReady_InHigh, SC_IrFetchCtrl_ExecDone_InHigh,
           SC_IrFetchCtrl_IR_OP, SC_IrFetchCtrl_IR_BIT13,
    output SC_IrFetchCtrl_PC_EnableBusA, SC_IrFetchCtrl_MemRead_Out,
           SC_IrFetchCtrl_IR_Write_Out, SC_IrFetchCtrl_IR_EnableBusB,
           SC_IrFetchCtrl_ExecStart_Out, SC_IrFetchCtrl_Class_Out,
           SC_IrFetchCtrl_PcInc_Out, SC_IrFetchCtrl_Busy_Out,
           SC_IrFetchCtrl_Error_Out, SC_IrFetchCtrl_InstrCount_Out,
           SC_IrFetchCtrl_State_Out
  );

  modport slave (
    output SC_IrFetchCtrl_Start_InHigh, SC_IrFetchCtrl_Halt_InHigh,
           SC_IrFetchCtrl_MemReady_InHigh, SC_IrFetchCtrl_ExecDone_InHigh,
           SC_IrFetchCtrl_IR_OP, SC_IrFetchCtrl_IR_BIT13,
    input  SC_IrFetchCtrl_PC_EnableBusA, SC_IrFetchCtrl_MemRead_Out,
           SC_IrFetchCtrl_IR_Write_Out, SC_IrFetchCtrl_IR_EnableBusB,
           SC_IrFetchCtrl_ExecStart_Out, SC_IrFetchCtrl_Class_Out,
           SC_IrFetchCtrl_PcInc_Out, SC_IrFetchCtrl_Busy_Out,
           SC_IrFetchCtrl_Error_Out, SC_IrFetchCtrl_InstrCount_Out,
           SC_IrFetchCtrl_State_Out
  );
endinterface

// File: rtl/sc_timeout_counter.sv
// Loadable up-counter with synchronous clear and a terminal-count flag that
// rises when the count reaches TIMEOUT_CYCLES-1.
module sc_timeout_counter #(
  parameter int TIMEOUT_WIDTH  = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     load,
  input  logic [TIMEOUT_WIDTH-1:0] load_val,
  input  logic                     en,
  output logic                     tc
);

  logic [TIMEOUT_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (clr)  count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= count + TIMEOUT_WIDTH'(1);
  end

  assign tc = (count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sc_ir_fetch_controller.sv
// Fetch/decode/execute microsequencer driving IR load and bus-enable controls.
// Every output is registered from the next-state decode, so it is valid in the named state.
module sc_ir_fetch_controller
  import sc_ir_fetch_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_WIDTH  = 5,
  parameter int COUNT_WIDTH    = 16
) (
  input logic                      SC_IrFetchCtrl_CLOCK_50,
  input logic                      SC_IrFetchCtrl_RESET_InLow,
  sc_ir_fetch_controller_if.master bus
);

  logic clk, rst_n;
  assign clk   = SC_IrFetchCtrl_CLOCK_50;
  assign rst_n = SC_IrFetchCtrl_RESET_InLow;

  state_t                 state_q, state_d;
  logic [1:0]             class_q, class_d;
  logic                   imm_q, imm_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic bus_a_q, mem_rd_q, ir_wr_q, bus_b_q, exec_start_q, pc_inc_q, busy_q, err_q;
  logic bus_a_d, mem_rd_d, ir_wr_d, bus_b_d, exec_start_d, pc_inc_d, busy_d, err_d;
  logic tmo_clr, tmo_en, tmo_tc;

  assign tmo_clr = (state_q == ST_FETCH);
  assign tmo_en  = (state_q == ST_WAIT) && !bus.SC_IrFetchCtrl_MemReady_InHigh;

  sc_timeout_counter #(
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .load    (1'b0),
    .load_val('0),
    .en      (tmo_en),
    .tc      (tmo_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      class_q      <= 2'b00;
      imm_q        <= 1'b0;
      cnt_q        <= '0;
      bus_a_q      <= 1'b0;
      mem_rd_q     <= 1'b0;
      ir_wr_q      <= 1'b0;
      bus_b_q      <= 1'b0;
      exec_start_q <= 1'b0;
      pc_inc_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      class_q      <= class_d;
      imm_q        <= imm_d;
      cnt_q        <= cnt_d;
      bus_a_q      <= bus_a_d;
      mem_rd_q     <= mem_rd_d;
      ir_wr_q      <= ir_wr_d;
      bus_b_q      <= bus_b_d;
      exec_start_q <= exec_start_d;
      pc_inc_q     <= pc_inc_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    imm_d   = imm_q;
    case (state_q)
      ST_IDLE:   if (bus.SC_IrFetchCtrl_Start_InHigh) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_WAIT;
      // Ready beats the timeout when both land on the terminal-count cycle
      ST_WAIT: begin
        if (bus.SC_IrFetchCtrl_MemReady_InHigh) state_d = ST_LOAD;
        else if (tmo_tc)                        state_d = ST_ERROR;
      end
      ST_LOAD:   state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (bus.SC_IrFetchCtrl_ExecDone_InHigh)
          state_d = bus.SC_IrFetchCtrl_Halt_InHigh ? ST_HALTED : ST_FETCH;
      end
      ST_HALTED: if (bus.SC_IrFetchCtrl_Start_InHigh) state_d = ST_FETCH;
      ST_ERROR:  if (bus.SC_IrFetchCtrl_Start_InHigh) state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase

    // IR settles on the falling edge inside LOAD, so it is captured leaving LOAD
    if (state_q == ST_LOAD) begin
      class_d = bus.SC_IrFetchCtrl_IR_OP;
      imm_d   = bus.SC_IrFetchCtrl_IR_BIT13 && (bus.SC_IrFetchCtrl_IR_OP == OP_ARITH);
    end

    pc_inc_d     = (state_q == ST_EXEC) && bus.SC_IrFetchCtrl_ExecDone_InHigh;
    cnt_d        = pc_inc_d ? cnt_q + COUNT_WIDTH'(1) : cnt_q;
    bus_a_d      = (state_d == ST_FETCH) || (state_d == ST_WAIT);
    mem_rd_d     = bus_a_d;
    ir_wr_d      = (state_d == ST_LOAD);
    exec_start_d = (state_d == ST_DECODE);
    bus_b_d      = (state_d == ST_EXEC) && imm_d;
    busy_d       = fsm_busy(state_d);
    err_d        = (state_d == ST_ERROR);
  end

  assign bus.SC_IrFetchCtrl_PC_EnableBusA  = bus_a_q;
  assign bus.SC_IrFetchCtrl_MemRead_Out    = mem_rd_q;
  assign bus.SC_IrFetchCtrl_IR_Write_Out   = ir_wr_q;
  assign bus.SC_IrFetchCtrl_IR_EnableBusB  = bus_b_q;
  assign bus.SC_IrFetchCtrl_ExecStart_Out  = exec_start_q;
  assign bus.SC_IrFetchCtrl_Class_Out      = class_q;
  assign bus.SC_IrFetchCtrl_PcInc_Out      = pc_inc_q;
  assign bus.SC_IrFetchCtrl_Busy_Out       = busy_q;
  assign bus.SC_IrFetchCtrl_Error_Out      = err_q;
  assign bus.SC_IrFetchCtrl_InstrCount_Out = cnt_q;
  assign bus.SC_IrFetchCtrl_State_Out      = state_q;

endmodule

// File: tb/tb_sc_ir_fetch_controller.sv
// Directed bench for the IR fetch microsequencer; a second instance with a
// 4-bit retired-instruction counter runs in lockstep to reach counter wrap.
module tb_sc_ir_fetch_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, halt, ready, done, ir_b13;
  logic [1:0] ir_op;
  int         n_cmp = 0;
  int         n_err = 0;
  int         exp_cnt = 0;
  logic       exp_busb;

  always #5 clk = ~clk;

  sc_ir_fetch_controller_if #(.COUNT_WIDTH(16)) ifc ();
  sc_ir_fetch_controller_if #(.COUNT_WIDTH(4))  ifn ();

  assign ifc.SC_IrFetchCtrl_Start_InHigh    = start;
  assign ifc.SC_IrFetchCtrl_Halt_InHigh     = halt;
  assign ifc.SC_IrFetchCtrl_MemReady_InHigh = ready;
  assign ifc.SC_IrFetchCtrl_ExecDone_InHigh = done;
  assign ifc.SC_IrFetchCtrl_IR_OP           = ir_op;
  assign ifc.SC_IrFetchCtrl_IR_BIT13        = ir_b13;
  assign ifn.SC_IrFetchCtrl_Start_InHigh    = start;
  assign ifn.SC_IrFetchCtrl_Halt_InHigh     = halt;
  assign ifn.SC_IrFetchCtrl_MemReady_InHigh = ready;
  assign ifn.SC_IrFetchCtrl_ExecDone_InHigh = done;
  assign ifn.SC_IrFetchCtrl_IR_OP           = ir_op;
  assign ifn.SC_IrFetchCtrl_IR_BIT13        = ir_b13;

  sc_ir_fetch_controller dut (
    .SC_IrFetchCtrl_CLOCK_50   (clk),
    .SC_IrFetchCtrl_RESET_InLow(rst_n),
    .bus                       (ifc)
  );

  sc_ir_fetch_controller #(.COUNT_WIDTH(4)) dut_n (
    .SC_IrFetchCtrl_CLOCK_50   (clk),
    .SC_IrFetchCtrl_RESET_InLow(rst_n),
    .bus                       (ifn)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_st"},    32'(ifc.SC_IrFetchCtrl_State_Out), 0);
    chk({tag, "_busa"},  32'(ifc.SC_IrFetchCtrl_PC_EnableBusA), 0);
    chk({tag, "_mrd"},   32'(ifc.SC_IrFetchCtrl_MemRead_Out), 0);
    chk({tag, "_irw"},   32'(ifc.SC_IrFetchCtrl_IR_Write_Out), 0);
    chk({tag, "_busb"},  32'(ifc.SC_IrFetchCtrl_IR_EnableBusB), 0);
    chk({tag, "_xst"},   32'(ifc.SC_IrFetchCtrl_ExecStart_Out), 0);
    chk({tag, "_cls"},   32'(ifc.SC_IrFetchCtrl_Class_Out), 0);
    chk({tag, "_pci"},   32'(ifc.SC_IrFetchCtrl_PcInc_Out), 0);
    chk({tag, "_busy"},  32'(ifc.SC_IrFetchCtrl_Busy_Out), 0);
    chk({tag, "_err"},   32'(ifc.SC_IrFetchCtrl_Error_Out), 0);
    chk({tag, "_cnt"},   32'(ifc.SC_IrFetchCtrl_InstrCount_Out), 0);
    chk({tag, "_cnt_n"}, 32'(ifn.SC_IrFetchCtrl_InstrCount_Out), 0);
  endtask

  // Entered in FETCH; returns in the first EXEC cycle.
  task automatic to_exec(input logic [1:0] op, input logic b13, input int nwait);
    ir_op    = op;
    ir_b13   = b13;
    exp_busb = b13 && (op == 2'b10);
    step();
    for (int i = 1; i <= nwait; i++) begin
      chk("wait_st",  32'(ifc.SC_IrFetchCtrl_State_Out), 2);
      chk("wait_mrd", 32'(ifc.SC_IrFetchCtrl_MemRead_Out), 1);
      chk("wait_busa", 32'(ifc.SC_IrFetchCtrl_PC_EnableBusA), 1);
      if (i == 1) chk("wait_pci", 32'(ifc.SC_IrFetchCtrl_PcInc_Out), 0);
      ready = (i == nwait);
      step();
    end
    ready = 1'b0;
    chk("load_st",  32'(ifc.SC_IrFetchCtrl_State_Out), 3);
    chk("load_irw", 32'(ifc.SC_IrFetchCtrl_IR_Write_Out), 1);
    chk("load_mrd", 32'(ifc.SC_IrFetchCtrl_MemRead_Out), 0);
    step();
    chk("dec_st",   32'(ifc.SC_IrFetchCtrl_State_Out), 4);
    chk("dec_xst",  32'(ifc.SC_IrFetchCtrl_ExecStart_Out), 1);
    chk("dec_cls",  32'(ifc.SC_IrFetchCtrl_Class_Out), 32'(op));
    chk("dec_busb", 32'(ifc.SC_IrFetchCtrl_IR_EnableBusB), 0);
    // Done/Halt/Start during DECODE must all be ignored
    done  = 1'b1;
    halt  = 1'b1;
    start = 1'b1;
    step();
    done  = 1'b0;
    halt  = 1'b0;
    start = 1'b0;
  endtask

  // Entered in the first EXEC cycle; returns in the first FETCH/HALTED cycle.
  task automatic finish_exec(input int nexec, input logic h);
    for (int j = 1; j <= nexec; j++) begin
      chk("exec_st",   32'(ifc.SC_IrFetchCtrl_State_Out), 5);
      chk("exec_busb", 32'(ifc.SC_IrFetchCtrl_IR_EnableBusB), 32'(exp_busb));
      chk("exec_xst",  32'(ifc.SC_IrFetchCtrl_ExecStart_Out), 0);
      chk("exec_pci",  32'(ifc.SC_IrFetchCtrl_PcInc_Out), 0);
      done = (j == nexec);
      halt = h && (j == nexec);
      step();
    end
    done = 1'b0;
    halt = 1'b0;
    exp_cnt++;
    chk("ret_st",    32'(ifc.SC_IrFetchCtrl_State_Out), h ? 6 : 1);
    chk("ret_pci",   32'(ifc.SC_IrFetchCtrl_PcInc_Out), 1);
    chk("ret_busy",  32'(ifc.SC_IrFetchCtrl_Busy_Out), h ? 0 : 1);
    chk("ret_busb",  32'(ifc.SC_IrFetchCtrl_IR_EnableBusB), 0);
    chk("ret_cnt",   32'(ifc.SC_IrFetchCtrl_InstrCount_Out), 32'(exp_cnt % 65536));
    chk("ret_cnt_n", 32'(ifn.SC_IrFetchCtrl_InstrCount_Out), 32'(exp_cnt % 16));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_irw_mrd",
          32'(ifc.SC_IrFetchCtrl_IR_Write_Out & ifc.SC_IrFetchCtrl_MemRead_Out), 0);
      chk("inv_busa_busb",
          32'(ifc.SC_IrFetchCtrl_PC_EnableBusA & ifc.SC_IrFetchCtrl_IR_EnableBusB), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; ready = 1'b0; done = 1'b0;
    ir_op = 2'b00; ir_b13 = 1'b0; exp_busb = 1'b0;
    #12;
    chk_zero("rst");
    #5 rst_n = 1'b1;
    step();
    chk("idle_st", 32'(ifc.SC_IrFetchCtrl_State_Out), 0);

    // Basic instruction: ARITH with immediate, ready on first WAIT, 3 EXEC cycles
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_fetch_st",   32'(ifc.SC_IrFetchCtrl_State_Out), 1);
    chk("t1_fetch_busy", 32'(ifc.SC_IrFetchCtrl_Busy_Out), 1);
    to_exec(2'b10, 1'b1, 1);
    finish_exec(3, 1'b0);

    // Halt with ExecDone, restart after 5 idle cycles
    to_exec(2'b01, 1'b1, 2);
    finish_exec(1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hlt_st",   32'(ifc.SC_IrFetchCtrl_State_Out), 6);
      chk("hlt_pci",  32'(ifc.SC_IrFetchCtrl_PcInc_Out), 0);
      chk("hlt_cls",  32'(ifc.SC_IrFetchCtrl_Class_Out), 1);
      chk("hlt_busa", 32'(ifc.SC_IrFetchCtrl_PC_EnableBusA), 0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("hlt_restart_st", 32'(ifc.SC_IrFetchCtrl_State_Out), 1);
    to_exec(2'b11, 1'b0, 1);
    finish_exec(1, 1'b0);

    // Memory timeout: 16 WAIT cycles with no ready
    step();
    for (int i = 1; i <= 16; i++) begin
      chk("tmo_wait_st", 32'(ifc.SC_IrFetchCtrl_State_Out), 2);
      step();
    end
    chk("tmo_err_st",   32'(ifc.SC_IrFetchCtrl_State_Out), 7);
    chk("tmo_err",      32'(ifc.SC_IrFetchCtrl_Error_Out), 1);
    chk("tmo_err_busy", 32'(ifc.SC_IrFetchCtrl_Busy_Out), 0);
    chk("tmo_err_mrd",  32'(ifc.SC_IrFetchCtrl_MemRead_Out), 0);
    halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("tmo_hold_st",  32'(ifc.SC_IrFetchCtrl_State_Out), 7);
      chk("tmo_hold_err", 32'(ifc.SC_IrFetchCtrl_Error_Out), 1);
    end
    halt  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("tmo_restart_st",  32'(ifc.SC_IrFetchCtrl_State_Out), 1);
    chk("tmo_restart_err", 32'(ifc.SC_IrFetchCtrl_Error_Out), 0);

    // Ready on the terminal-count WAIT cycle wins over the timeout
    to_exec(2'b00, 1'b0, 16);
    finish_exec(1, 1'b0);

    // Asynchronous reset in the middle of WAIT
    step();
    chk("arst_w_pre_st", 32'(ifc.SC_IrFetchCtrl_State_Out), 2);
    #3 rst_n = 1'b0;
    #1 chk_zero("arst_wait");
    exp_cnt = 0;
    #2 rst_n = 1'b1;
    step();
    chk("arst_w_idle", 32'(ifc.SC_IrFetchCtrl_State_Out), 0);

    // Asynchronous reset in the middle of EXEC, with a nonzero count
    start = 1'b1;
    step();
    start = 1'b0;
    to_exec(2'b10, 1'b1, 1);
    finish_exec(1, 1'b0);
    to_exec(2'b10, 1'b1, 1);
    chk("arst_x_pre_busb", 32'(ifc.SC_IrFetchCtrl_IR_EnableBusB), 1);
    #3 rst_n = 1'b0;
    #1 chk_zero("arst_exec");
    exp_cnt = 0;
    #2 rst_n = 1'b1;
    step();

    // Counter wrap on the narrow instance after 16 BRANCH instructions
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 16; n++) begin
      to_exec(2'b00, 1'b1, 1);
      finish_exec(1, 1'b0);
    end
    chk("wrap_cnt_n", 32'(ifn.SC_IrFetchCtrl_InstrCount_Out), 0);
    chk("wrap_cnt",   32'(ifc.SC_IrFetchCtrl_InstrCount_Out), 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
